// File: rtl/mac_requant_pkg.sv
// Shared widths, saturation bounds and rounding/saturation helpers for the
// MAC requantisation stage.
package mac_requant_pkg;

  localparam int IMG_WIDTH   = 16;
  localparam int KER_WIDTH   = 16;
  localparam int ACC_WIDTH   = IMG_WIDTH + KER_WIDTH + 1;
  localparam int BIAS_WIDTH  = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int FIFO_DEPTH  = 4;
  // delta + bias needs one extra bit, the rounding add one more
  localparam int SUM_WIDTH   = ACC_WIDTH + 2;

  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
    {{(SUM_WIDTH-IMG_WIDTH+1){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN =
    {{(SUM_WIDTH-IMG_WIDTH+1){1'b1}}, {(IMG_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [BIAS_WIDTH-1:0]  bias;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu;
  } cfg_t;

  function automatic logic [SUM_WIDTH-1:0] round_const(input logic [SHIFT_WIDTH-1:0] sh);
    logic [SUM_WIDTH-1:0] one;
    one = {{(SUM_WIDTH-1){1'b0}}, 1'b1};
    return (sh == '0) ? '0 : (one << (sh - SHIFT_WIDTH'(1)));
  endfunction

  function automatic logic [IMG_WIDTH-1:0] saturate(input logic signed [SUM_WIDTH-1:0] x,
                                                    input logic relu);
    logic [IMG_WIDTH-1:0] r;
    if (x > SAT_MAX) begin
      r = {1'b0, {(IMG_WIDTH-1){1'b1}}};
    end else if (x < SAT_MIN) begin
      r = {1'b1, {(IMG_WIDTH-1){1'b0}}};
    end else begin
      r = x[IMG_WIDTH-1:0];
    end
    return (relu && r[IMG_WIDTH-1]) ? '0 : r;
  endfunction

endpackage

// File: rtl/mac_requant_fifo_fwft.sv
// First-word-fall-through queue with a registered head; a push into an empty
// queue bypasses storage and lands directly in the output register.
module fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  input  logic                     pop,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    mem_cnt_r;
  logic             out_val_r;
  logic [WIDTH-1:0] data_r;
  logic             load_out_s, take_mem_s, bypass_s, mem_push_s;

  // head register free or being consumed decides where the next word goes
  always_comb begin
    load_out_s = !out_val_r || pop;
    take_mem_s = load_out_s && (mem_cnt_r != '0);
    bypass_s   = load_out_s && (mem_cnt_r == '0) && push;
    mem_push_s = push && !bypass_s;
  end

  assign count = mem_cnt_r + CW'(out_val_r);
  assign full  = (count == CW'(DEPTH));
  assign empty = !out_val_r;
  assign data  = data_r;

  // storage, pointers and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      mem_cnt_r <= '0;
      out_val_r <= 1'b0;
      data_r    <= '0;
    end else begin
      mem_cnt_r <= mem_cnt_r + CW'(mem_push_s) - CW'(take_mem_s);
      if (mem_push_s) begin
        mem[wr_ptr_r] <= wdata;
        wr_ptr_r      <= wr_ptr_r + AW'(1);
      end
      if (take_mem_s) begin
        data_r    <= mem[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + AW'(1);
        out_val_r <= 1'b1;
      end else if (bypass_s) begin
        data_r    <= wdata;
        out_val_r <= 1'b1;
      end else if (load_out_s) begin
        out_val_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mac_requant.sv
// Window-sum requantisation: delta vs. snapshot, bias, round-half-up shift,
// saturate/ReLU, then a credit-protected output queue.
module mac_requant
  import mac_requant_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic                   acc_take,
  input  logic                   acc_rebase,
  input  logic [BIAS_WIDTH-1:0]  cfg_bias,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_relu,
  output logic [IMG_WIDTH-1:0]   dout,
  output logic                   dout_val,
  input  logic                   dout_rdy,
  output logic                   drop
);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int CREDIT_W = CNT_W + 1;

  logic [ACC_WIDTH-1:0]        snapshot_r;
  logic                        s1_val_r, s2_val_r, s3_val_r, s4_val_r;
  logic [ACC_WIDTH-1:0]        s1_delta_r;
  cfg_t                        s1_cfg_r;
  logic signed [SUM_WIDTH-1:0] s2_sum_r, s3_shr_r;
  logic [SHIFT_WIDTH-1:0]      s2_shift_r;
  logic                        s2_relu_r, s3_relu_r;
  logic [IMG_WIDTH-1:0]        s4_data_r;
  logic                        drop_r;

  logic [2:0]                  inflight_s;
  logic [CREDIT_W-1:0]         credit_s;
  logic                        take_ok_s;
  logic signed [SUM_WIDTH-1:0] s1_sum_s;
  logic [CNT_W-1:0]            fifo_count_s;
  logic                        fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;

  // a take is accepted only if every in-flight result is guaranteed a slot
  always_comb begin
    inflight_s = 3'(s1_val_r) + 3'(s2_val_r) + 3'(s3_val_r) + 3'(s4_val_r);
    credit_s   = CREDIT_W'(fifo_count_s) + CREDIT_W'(inflight_s);
    take_ok_s  = acc_take && (credit_s < CREDIT_W'(FIFO_DEPTH));
    s1_sum_s   = {{(SUM_WIDTH-ACC_WIDTH){s1_delta_r[ACC_WIDTH-1]}}, s1_delta_r}
               + {{(SUM_WIDTH-BIAS_WIDTH){s1_cfg_r.bias[BIAS_WIDTH-1]}}, s1_cfg_r.bias}
               + round_const(s1_cfg_r.shift);
  end

  // snapshot, S1..S4 pipeline and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot_r <= '0;
      s1_val_r   <= 1'b0;
      s2_val_r   <= 1'b0;
      s3_val_r   <= 1'b0;
      s4_val_r   <= 1'b0;
      s1_delta_r <= '0;
      s1_cfg_r   <= '0;
      s2_sum_r   <= '0;
      s2_shift_r <= '0;
      s2_relu_r  <= 1'b0;
      s3_shr_r   <= '0;
      s3_relu_r  <= 1'b0;
      s4_data_r  <= '0;
      drop_r     <= 1'b0;
    end else begin
      // snapshot moves even on a discarded take so later windows stay right
      if (acc_take || acc_rebase) snapshot_r <= acc;
      s1_val_r <= take_ok_s;
      if (take_ok_s) begin
        s1_delta_r <= acc - snapshot_r;
        s1_cfg_r   <= '{bias: cfg_bias, shift: cfg_shift, relu: cfg_relu};
      end
      if (acc_take && !take_ok_s) drop_r <= 1'b1;

      s2_val_r   <= s1_val_r;
      s2_sum_r   <= s1_sum_s;
      s2_shift_r <= s1_cfg_r.shift;
      s2_relu_r  <= s1_cfg_r.relu;

      s3_val_r   <= s2_val_r;
      s3_shr_r   <= s2_sum_r >>> s2_shift_r;
      s3_relu_r  <= s2_relu_r;

      s4_val_r   <= s3_val_r;
      s4_data_r  <= saturate(s3_shr_r, s3_relu_r);
    end
  end

  assign fifo_push_s = s4_val_r && !fifo_full_s;
  assign fifo_pop_s  = dout_val && dout_rdy;
  assign dout_val    = !fifo_empty_s;
  assign drop        = drop_r;

  fifo_fwft #(
    .WIDTH(IMG_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .wdata (s4_data_r),
    .full  (fifo_full_s),
    .pop   (fifo_pop_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s),
    .data  (dout)
  );

endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: vector table for the arithmetic, plus
// sequences for latency, back-pressure/credit drop and mid-flight reset.
module tb_mac_requant;
  import mac_requant_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   acc_take, acc_rebase;
  logic [BIAS_WIDTH-1:0]  cfg_bias;
  logic [SHIFT_WIDTH-1:0] cfg_shift;
  logic                   cfg_relu;
  logic [IMG_WIDTH-1:0]   dout;
  logic                   dout_val, dout_rdy, drop;

  int checks   = 0;
  int failures = 0;

  mac_requant dut (
    .clk(clk), .rst(rst), .acc(acc), .acc_take(acc_take), .acc_rebase(acc_rebase),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .dout(dout), .dout_val(dout_val), .dout_rdy(dout_rdy), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_WIDTH-1:0]   base;
    logic [ACC_WIDTH-1:0]   a;
    logic [BIAS_WIDTH-1:0]  bias;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu;
    logic [IMG_WIDTH-1:0]   exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rebase(input logic [ACC_WIDTH-1:0] a);
    acc = a; acc_rebase = 1'b1;
    step();
    acc_rebase = 1'b0;
  endtask

  task automatic do_take(input logic [ACC_WIDTH-1:0] a, input logic [BIAS_WIDTH-1:0] b,
                         input logic [SHIFT_WIDTH-1:0] s, input logic r);
    acc = a; cfg_bias = b; cfg_shift = s; cfg_relu = r; acc_take = 1'b1;
    step();
    acc_take = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [IMG_WIDTH-1:0] exp);
    int n;
    n = 0;
    while (!dout_val && n < 12) begin
      step();
      n++;
    end
    check(name, {dout_val, dout}, {1'b1, exp});
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{33'd100,          33'd130,          16'd5,      5'd0,  1'b0, 16'd35};
    vecs[1]  = '{33'd0,            33'd7,            16'd0,      5'd1,  1'b0, 16'd4};
    vecs[2]  = '{33'd7,            33'd0,            16'd0,      5'd1,  1'b0, 16'hFFFD};
    vecs[3]  = '{33'd0,            33'd5,            16'd0,      5'd1,  1'b0, 16'd3};
    vecs[4]  = '{33'd0,            33'h0_0010_0000,  16'd0,      5'd0,  1'b0, 16'h7FFF};
    vecs[5]  = '{33'h0_0010_0000,  33'd0,            16'd0,      5'd0,  1'b0, 16'h8000};
    vecs[6]  = '{33'h0_0010_0000,  33'd0,            16'd0,      5'd0,  1'b1, 16'h0000};
    vecs[7]  = '{33'h1_FFFF_FFF6,  33'd5,            16'd0,      5'd0,  1'b0, 16'd15};
    vecs[8]  = '{33'd0,            33'd1000,         16'hFA24,   5'd2,  1'b0, 16'hFF83};
    vecs[9]  = '{33'd0,            33'd300,          16'd0,      5'd3,  1'b1, 16'd38};
    vecs[10] = '{33'd0,            33'h0_FFFF_FFFF,  16'd0,      5'd31, 1'b0, 16'd2};
    vecs[11] = '{33'h1_0000_0000,  33'd0,            16'd0,      5'd31, 1'b0, 16'hFFFE};
    vecs[12] = '{33'd0,            33'd32767,        16'd1,      5'd0,  1'b0, 16'h7FFF};

    rst = 1'b1; acc = '0; acc_take = 1'b0; acc_rebase = 1'b0;
    cfg_bias = '0; cfg_shift = '0; cfg_relu = 1'b0; dout_rdy = 1'b1;
    step(); step();
    check("reset_dout_val", dout_val, 1'b0);
    check("reset_dout", dout, 16'd0);
    check("reset_drop", drop, 1'b0);
    rst = 1'b0;
    step();

    // latency: take at N, dout_val rises at N+5
    do_rebase(33'd100);
    do_take(33'd130, 16'd5, 5'd0, 1'b0);
    step(); step(); step();
    check("latency_not_yet", dout_val, 1'b0);
    step();
    check("latency_n5", {dout_val, dout}, {1'b1, 16'd35});
    step();

    for (int i = 0; i < 13; i++) begin
      do_rebase(vecs[i].base);
      do_take(vecs[i].a, vecs[i].bias, vecs[i].shift, vecs[i].relu);
      wait_out($sformatf("vec%0d", i), vecs[i].exp);
      step();
    end

    // back-pressure: six takes, only four fit, drop from the fifth
    dout_rdy = 1'b0;
    do_rebase(33'd0);
    do_take(33'd1,  16'd0, 5'd0, 1'b0);
    do_take(33'd3,  16'd0, 5'd0, 1'b0);
    do_take(33'd6,  16'd0, 5'd0, 1'b0);
    do_take(33'd10, 16'd0, 5'd0, 1'b0);
    check("drop_after_4", drop, 1'b0);
    do_take(33'd15, 16'd0, 5'd0, 1'b0);
    check("drop_after_5", drop, 1'b1);
    do_take(33'd21, 16'd0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("bp_head", {dout_val, dout}, {1'b1, 16'd1});
    step();
    check("bp_hold", {dout_val, dout}, {1'b1, 16'd1});
    dout_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_out%0d", k), {dout_val, dout}, {1'b1, 16'(k)});
      step();
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | dout_val;
      step();
    end
    check("bp_no_extra", seen, 1'b0);
    check("drop_sticky", drop, 1'b1);

    // reset with three results in flight
    do_rebase(33'd0);
    do_take(33'd100, 16'd0, 5'd0, 1'b0);
    do_take(33'd200, 16'd0, 5'd0, 1'b0);
    do_take(33'd300, 16'd0, 5'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_val", dout_val, 1'b0);
    check("rst_clears_drop", drop, 1'b0);
    step();
    check("rst_edge_val", dout_val, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | dout_val;
    end
    check("rst_no_partial", seen, 1'b0);
    do_take(33'd50, 16'd0, 5'd0, 1'b0);
    wait_out("post_rst_snapshot0", 16'd50);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
